// File: rtl/audio_seq_pkg.sv
// Shared types, default widths and the level magnitude helper
// for the audio stream sequencer.
package audio_seq_pkg;

    localparam int DATA_W_DEF = 32;
    localparam int PER_W_DEF  = 17;

    typedef enum logic [1:0] {
        IDLE,
        READ,
        PROC,
        WRITE
    } seq_state_t;

    // 0x8000 has no positive counterpart, so it clips to 0x7FFF
    function automatic logic [15:0] sat_abs16(input logic [15:0] v);
        logic [15:0] neg;
        neg = ~v + 16'd1;
        if (v == 16'h8000)
            return 16'h7fff;
        else if (v[15])
            return neg;
        else
            return v;
    endfunction

endpackage

// File: rtl/audio_gate_timer.sv
// Square-wave mute gate with an optional self-sweeping half-period.
// A zero half-period bypasses the gate (mute held low).
module audio_gate_timer
    import audio_seq_pkg::*;
#(
    parameter int PER_W     = PER_W_DEF,
    parameter int SWEEP_DIV = 16
) (
    input  logic             CLOCK_50,
    input  logic             reset,
    input  logic [PER_W-1:0] period_in,
    input  logic             sweep_en,
    output logic             mute
);

    localparam int PS_W = (SWEEP_DIV > 1) ? $clog2(SWEEP_DIV) : 1;
    localparam logic [PS_W-1:0] PS_LAST = PS_W'(SWEEP_DIV - 1);

    logic [PER_W-1:0] gate_cnt;
    logic [PER_W-1:0] sweep_reg;
    logic [PER_W-1:0] period_eff;
    logic [PS_W-1:0]  prescale;

    assign period_eff = sweep_en ? sweep_reg : period_in;

    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) begin
            gate_cnt  <= '0;
            mute      <= 1'b0;
            prescale  <= '0;
            sweep_reg <= PER_W'(1);
        end else begin
            // sweep never lands on 0 so it cannot fall into bypass
            if (sweep_en) begin
                if (prescale == PS_LAST) begin
                    prescale  <= '0;
                    sweep_reg <= (&sweep_reg) ? PER_W'(1)
                                              : sweep_reg + PER_W'(1);
                end else begin
                    prescale <= prescale + PS_W'(1);
                end
            end
            if (period_eff == '0) begin
                gate_cnt <= '0;
                mute     <= 1'b0;
            end else if (gate_cnt >= period_eff) begin
                gate_cnt <= '0;
                mute     <= ~mute;
            end else begin
                gate_cnt <= gate_cnt + PER_W'(1);
            end
        end
    end

endmodule

// File: rtl/audio_stream_sequencer.sv
// Codec read -> gate -> write sequencer with a left-channel level meter.
// Define AUDIO_SEQ_PEAK_HOLD_EN for a decaying peak-hold level.
module audio_stream_sequencer
    import audio_seq_pkg::*;
#(
    parameter int DATA_W    = DATA_W_DEF,
    parameter int PER_W     = PER_W_DEF,
    parameter int SWEEP_DIV = 16
) (
    input  logic              CLOCK_50,
    input  logic              reset,
    input  logic [PER_W-1:0]  period_in,
    input  logic              sweep_en,
    input  logic              audio_in_available,
    input  logic              audio_out_allowed,
    input  logic [DATA_W-1:0] left_channel_audio_in,
    input  logic [DATA_W-1:0] right_channel_audio_in,
    output logic              read_audio_in,
    output logic              write_audio_out,
    output logic [DATA_W-1:0] left_channel_audio_out,
    output logic [DATA_W-1:0] right_channel_audio_out,
    output logic [15:0]       level,
    output logic              busy
);

    seq_state_t        state;
    logic              mute;
    logic [DATA_W-1:0] left_q;
    logic [DATA_W-1:0] right_q;
    logic [15:0]       mag;

    audio_gate_timer #(
        .PER_W     (PER_W),
        .SWEEP_DIV (SWEEP_DIV)
    ) u_gate (
        .CLOCK_50  (CLOCK_50),
        .reset     (reset),
        .period_in (period_in),
        .sweep_en  (sweep_en),
        .mute      (mute)
    );

    assign write_audio_out = (state == WRITE) && audio_out_allowed;
    assign mag = sat_abs16(left_channel_audio_out[DATA_W-1 -: 16]);

    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) begin
            state                   <= IDLE;
            read_audio_in           <= 1'b0;
            busy                    <= 1'b0;
            left_q                  <= '0;
            right_q                 <= '0;
            left_channel_audio_out  <= '0;
            right_channel_audio_out <= '0;
        end else begin
            read_audio_in <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (audio_in_available && audio_out_allowed) begin
                        state         <= READ;
                        read_audio_in <= 1'b1;
                        busy          <= 1'b1;
                    end
                end
                READ: begin
                    left_q  <= left_channel_audio_in;
                    right_q <= right_channel_audio_in;
                    state   <= PROC;
                end
                // mute is looked at here only; later toggles wait for the next pair
                PROC: begin
                    left_channel_audio_out  <= mute ? '0 : left_q;
                    right_channel_audio_out <= mute ? '0 : right_q;
                    state                   <= WRITE;
                end
                WRITE: begin
                    if (audio_out_allowed) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end
                end
            endcase
        end
    end

`ifdef AUDIO_SEQ_PEAK_HOLD_EN
    logic [15:0] decay_cnt;

    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) begin
            level     <= '0;
            decay_cnt <= '0;
        end else begin
            decay_cnt <= decay_cnt + 16'd1;
            if (write_audio_out) begin
                if (mag > level)
                    level <= mag;
            end else if ((&decay_cnt) && (level != '0)) begin
                level <= level - 16'd1;
            end
        end
    end
`else
    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset)
            level <= '0;
        else if (write_audio_out)
            level <= mag;
    end
`endif

endmodule

// File: tb/tb_audio_stream_sequencer.sv
// Self-checking bench for audio_stream_sequencer: random samples
// against an arithmetic reference of timing, gating and level.
module tb_audio_stream_sequencer;

    localparam int DW = 32;
    localparam int PW = 8;
`ifdef AUDIO_SEQ_PEAK_HOLD_EN
    localparam bit PEAK = 1'b1;
`else
    localparam bit PEAK = 1'b0;
`endif

    logic          CLOCK_50 = 1'b0;
    logic          reset;
    logic [PW-1:0] period_in;
    logic          sweep_en;
    logic          avail;
    logic          allowed;
    logic [DW-1:0] lin;
    logic [DW-1:0] rin;
    logic          rd;
    logic          wr;
    logic [DW-1:0] lout;
    logic [DW-1:0] rout;
    logic [15:0]   level;
    logic          busy;

    int total = 0;
    int bad = 0;
    int ecnt;
    logic [15:0] lvl_m;

    audio_stream_sequencer #(
        .DATA_W    (DW),
        .PER_W     (PW),
        .SWEEP_DIV (16)
    ) dut (
        .CLOCK_50                (CLOCK_50),
        .reset                   (reset),
        .period_in               (period_in),
        .sweep_en                (sweep_en),
        .audio_in_available      (avail),
        .audio_out_allowed       (allowed),
        .left_channel_audio_in   (lin),
        .right_channel_audio_in  (rin),
        .read_audio_in           (rd),
        .write_audio_out         (wr),
        .left_channel_audio_out  (lout),
        .right_channel_audio_out (rout),
        .level                   (level),
        .busy                    (busy)
    );

    always #5 CLOCK_50 = ~CLOCK_50;

    // rising edges since reset release
    always @(posedge CLOCK_50 or posedge reset)
        if (reset) ecnt <= 0;
        else ecnt <= ecnt + 1;

    function automatic logic [15:0] mag_of(input logic [31:0] s);
        logic [15:0] hi;
        int v;
        hi = s[31:16];
        v = $signed(hi);
        if (v < 0) v = -v;
        if (v > 32767) v = 32767;
        return 16'(v);
    endfunction

    function automatic logic [15:0] next_level(input logic [15:0] cur,
                                               input logic [31:0] left);
        logic [15:0] m;
        m = mag_of(left);
        return (PEAK && cur > m) ? cur : m;
    endfunction

    function automatic logic [PW-1:0] sweep_model(input int n);
        return PW'(1 + ((n / 16) % ((1 << PW) - 1)));
    endfunction

    task automatic do_reset();
        reset = 1'b1;
        avail = 1'b0;
        allowed = 1'b0;
        period_in = '0;
        sweep_en = 1'b0;
        lin = '0;
        rin = '0;
        lvl_m = '0;
        repeat (2) @(negedge CLOCK_50);
        reset = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        avail = 1'b1;
        allowed = 1'b1;
        period_in = '0;
        sweep_en = 1'b0;
        #1;
        total++;
        if ({rd, wr, busy, level, lout, rout} !== '0) begin
            bad++;
            $display("FAIL reset_outs: got rd%b wr%b busy%b lvl%h l%h r%h want all 0",
                     rd, wr, busy, level, lout, rout);
        end
        total++;
        if (dut.u_gate.sweep_reg !== PW'(1)) begin
            bad++;
            $display("FAIL reset_sweep: got %h want 1", dut.u_gate.sweep_reg);
        end
        allowed = 1'b0;
        repeat (2) @(negedge CLOCK_50);
        reset = 1'b0;
        repeat (3) begin
            @(negedge CLOCK_50);
            total++;
            if ({rd, busy} !== 2'b00) begin
                bad++;
                $display("FAIL idle_hold: got rd%b busy%b want 00", rd, busy);
            end
        end
    endtask

    task automatic test_bypass();
        logic [63:0] q[$];
        logic [63:0] e;
        int prev_rd;
        bit chk_lvl;
        prev_rd = -1;
        chk_lvl = 0;
        do_reset();
        avail = 1'b1;
        allowed = 1'b1;
        lin = 32'h1234_0000;
        rin = $urandom;
        for (int i = 0; i < 48; i++) begin
            @(negedge CLOCK_50);
            if (chk_lvl) begin
                chk_lvl = 0;
                total++;
                if (level !== lvl_m) begin
                    bad++;
                    $display("FAIL byp_level: got %h want %h", level, lvl_m);
                end
            end
            if (rd) begin
                q.push_back({lin, rin});
                total++;
                if ((prev_rd < 0 && ecnt != 1) || (prev_rd >= 0 && ecnt - prev_rd != 4)) begin
                    bad++;
                    $display("FAIL byp_rd_spacing: got edge %0d want prev %0d + 4", ecnt, prev_rd);
                end
                prev_rd = ecnt;
            end
            if (wr) begin
                total++;
                if (q.size() == 0 || ecnt != prev_rd + 2) begin
                    bad++;
                    $display("FAIL byp_wr_timing: got edge %0d want %0d", ecnt, prev_rd + 2);
                end else begin
                    e = q.pop_front();
                    total++;
                    if ({lout, rout} !== e) begin
                        bad++;
                        $display("FAIL byp_data: got %h want %h", {lout, rout}, e);
                    end
                    lvl_m = next_level(lvl_m, e[63:32]);
                    chk_lvl = 1;
                end
            end
            @(posedge CLOCK_50);
            #1;
            lin = $urandom;
            rin = $urandom;
        end
    endtask

    task automatic test_gate();
        logic [63:0] q[$];
        logic [63:0] e;
        logic [63:0] z;
        int nm;
        do_reset();
        period_in = PW'(10);
        avail = 1'b1;
        allowed = 1'b1;
        nm = 0;
        for (int i = 0; i < 70; i++) begin
            @(posedge CLOCK_50);
            #1;
            lin = $urandom | 32'h1;
            rin = $urandom | 32'h1;
            @(negedge CLOCK_50);
            total++;
            if (dut.u_gate.mute !== 1'((ecnt / 11) % 2)) begin
                bad++;
                $display("FAIL gate_mute: edge %0d got %b want %b",
                         ecnt, dut.u_gate.mute, 1'((ecnt / 11) % 2));
            end
            if (rd) begin
                // PROC occupies the cycle after edge ecnt+1
                if (((ecnt + 1) / 11) % 2 == 1) begin
                    z = '0;
                    q.push_back(z);
                    nm++;
                end else begin
                    q.push_back({lin, rin});
                end
            end
            if (wr) begin
                total++;
                if (q.size() == 0) begin
                    bad++;
                    $display("FAIL gate_extra_wr: got write at edge %0d want none", ecnt);
                end else begin
                    e = q.pop_front();
                    if ({lout, rout} !== e) begin
                        bad++;
                        $display("FAIL gate_data: edge %0d got %h want %h", ecnt, {lout, rout}, e);
                    end
                end
            end
        end
        total++;
        if (nm == 0) begin
            bad++;
            $display("FAIL gate_coverage: got %0d muted pairs want >0", nm);
        end
    endtask

    task automatic test_backpressure();
        logic [63:0] e;
        int nwr;
        do_reset();
        avail = 1'b1;
        allowed = 1'b1;
        lin = $urandom;
        rin = $urandom;
        @(negedge CLOCK_50);
        e = {lin, rin};
        total++;
        if (rd !== 1'b1) begin
            bad++;
            $display("FAIL bp_first_rd: got %b want 1", rd);
        end
        allowed = 1'b0;
        @(posedge CLOCK_50);
        #1;
        lin = ~lin;
        rin = ~rin;
        @(negedge CLOCK_50);
        nwr = 0;
        repeat (7) begin
            @(negedge CLOCK_50);
            nwr += int'(wr);
            total++;
            if ({rd, wr, busy} !== 3'b001) begin
                bad++;
                $display("FAIL bp_hold: got rd%b wr%b busy%b want 001", rd, wr, busy);
            end
        end
        allowed = 1'b1;
        #1;
        nwr += int'(wr);
        total++;
        if (wr !== 1'b1 || {lout, rout} !== e) begin
            bad++;
            $display("FAIL bp_release: got wr%b %h want wr1 %h", wr, {lout, rout}, e);
        end
        @(negedge CLOCK_50);
        nwr += int'(wr);
        total++;
        if ({rd, wr, busy} !== 3'b000 || nwr != 1) begin
            bad++;
            $display("FAIL bp_idle: got rd%b wr%b busy%b writes %0d want 000 writes 1",
                     rd, wr, busy, nwr);
        end
        @(negedge CLOCK_50);
        total++;
        if (rd !== 1'b1) begin
            bad++;
            $display("FAIL bp_next_rd: got %b want 1", rd);
        end
    endtask

    task automatic test_reset_mid();
        logic [31:0] l1;
        do_reset();
        avail = 1'b1;
        allowed = 1'b1;
        l1 = $urandom | 32'h0001_0001;
        lin = l1;
        rin = $urandom | 32'h1;
        repeat (3) @(negedge CLOCK_50);
        total++;
        if (wr !== 1'b1 || lout !== l1) begin
            bad++;
            $display("FAIL mid_first_pair: got wr%b %h want wr1 %h", wr, lout, l1);
        end
        repeat (3) @(negedge CLOCK_50);
        reset = 1'b1;
        #1;
        total++;
        if ({rd, wr, busy, level, lout, rout} !== '0) begin
            bad++;
            $display("FAIL mid_reset_outs: got rd%b wr%b busy%b lvl%h l%h r%h want all 0",
                     rd, wr, busy, level, lout, rout);
        end
        avail = 1'b0;
        repeat (2) @(negedge CLOCK_50);
        reset = 1'b0;
        total++;
        if (dut.u_gate.sweep_reg !== PW'(1)) begin
            bad++;
            $display("FAIL mid_sweep: got %h want 1", dut.u_gate.sweep_reg);
        end
        repeat (5) begin
            @(negedge CLOCK_50);
            total++;
            if ({rd, wr, busy} !== 3'b000) begin
                bad++;
                $display("FAIL mid_abandon: got rd%b wr%b busy%b want 000", rd, wr, busy);
            end
        end
        avail = 1'b1;
        @(negedge CLOCK_50);
        total++;
        if (rd !== 1'b1) begin
            bad++;
            $display("FAIL mid_fresh_rd: got %b want 1", rd);
        end
    endtask

    task automatic test_sweep();
        int n;
        n = 0;
        do_reset();
        sweep_en = 1'b1;
        while (n < 20) begin
            @(negedge CLOCK_50);
            n++;
            if (n inside {15, 16, 20}) begin
                total++;
                if (dut.u_gate.sweep_reg !== sweep_model(n)) begin
                    bad++;
                    $display("FAIL sweep_step: n %0d got %h want %h",
                             n, dut.u_gate.sweep_reg, sweep_model(n));
                end
            end
        end
        sweep_en = 1'b0;
        repeat (30) @(negedge CLOCK_50);
        total++;
        if (dut.u_gate.sweep_reg !== sweep_model(n)) begin
            bad++;
            $display("FAIL sweep_hold: got %h want %h", dut.u_gate.sweep_reg, sweep_model(n));
        end
        sweep_en = 1'b1;
        while (n < 4080) begin
            @(negedge CLOCK_50);
            n++;
            if (n inside {31, 32, 4064, 4079, 4080}) begin
                total++;
                if (dut.u_gate.sweep_reg !== sweep_model(n)) begin
                    bad++;
                    $display("FAIL sweep_wrap: n %0d got %h want %h",
                             n, dut.u_gate.sweep_reg, sweep_model(n));
                end
            end
        end
        sweep_en = 1'b0;
    endtask

    task automatic test_level_sat();
        int nrd;
        do_reset();
        avail = 1'b1;
        allowed = 1'b1;
        lin = 32'h8000_0000;
        rin = $urandom;
        nrd = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge CLOCK_50);
            if (rd) nrd++;
            if (ecnt == 3) begin
                total++;
                if (wr !== 1'b1 || lout !== 32'h8000_0000) begin
                    bad++;
                    $display("FAIL sat_out: got wr%b %h want wr1 80000000", wr, lout);
                end
            end
            if (ecnt == 4) begin
                total++;
                if (level !== 16'h7fff) begin
                    bad++;
                    $display("FAIL sat_level: got %h want 7fff", level);
                end
            end
            if (ecnt == 8) begin
                total++;
                if (level !== (PEAK ? 16'h7fff : 16'h0001)) begin
                    bad++;
                    $display("FAIL sat_second: got %h want %h",
                             level, PEAK ? 16'h7fff : 16'h0001);
                end
            end
            @(posedge CLOCK_50);
            #1;
            if (nrd >= 1) lin = 32'h0001_0000;
            if (nrd >= 2) avail = 1'b0;
        end
        if (PEAK) begin
            while (ecnt < 65535) @(negedge CLOCK_50);
            total++;
            if (level !== 16'h7fff) begin
                bad++;
                $display("FAIL decay_early: got %h want 7fff", level);
            end
            @(negedge CLOCK_50);
            total++;
            if (level !== 16'h7ffe) begin
                bad++;
                $display("FAIL decay_step: got %h want 7ffe", level);
            end
        end
    endtask

    initial begin
        test_reset();
        test_bypass();
        test_gate();
        test_backpressure();
        test_reset_mid();
        test_sweep();
        test_level_sat();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
